// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
//==============================================================================
// Module      : fwd_scoreboard_if
// Description : Bundles the signals between the pipeline and the operand
//               forwarding / long-latency scoreboard unit.
//               Per-port and per-source vectors are flattened. Port or
//               source i occupies slice [i*W +: W].
//   rd_req/rd_orig/rd_en      : operand read requests from decode
//   rd_value/rd_stall         : forwarded operands and gated per-port stalls
//   stall_exec                : OR of all per-port stalls
//   src_wen/valid/reg/value   : bypass sources, index 0 youngest
//   issue_valid/reg           : long-latency op issue
//   cmpl_valid/reg/value      : long-latency op completion bus
//   flush                     : kills outstanding long-latency writebacks
//   pending_any/stall_cycles  : registered status outputs
// Revision    : 1.0 - initial release
//==============================================================================
interface fwd_scoreboard_if #(
    parameter int NUM_RD  = 2,
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5
);
    logic [NUM_RD*REG_W-1:0]    rd_req;
    logic [NUM_RD*DATA_W-1:0]   rd_orig;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*DATA_W-1:0]   rd_value;
    logic [NUM_RD-1:0]          rd_stall;
    logic                       stall_exec;
    logic [NUM_SRC-1:0]         src_wen;
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC*REG_W-1:0]   src_reg;
    logic [NUM_SRC*DATA_W-1:0]  src_value;
    logic                       issue_valid;
    logic [REG_W-1:0]           issue_reg;
    logic                       cmpl_valid;
    logic [REG_W-1:0]           cmpl_reg;
    logic [DATA_W-1:0]          cmpl_value;
    logic                       flush;
    logic                       pending_any;
    logic [31:0]                stall_cycles;

    // Pipeline side
    modport master (
        output rd_req, rd_orig, rd_en,
        output src_wen, src_valid, src_reg, src_value,
        output issue_valid, issue_reg,
        output cmpl_valid, cmpl_reg, cmpl_value,
        output flush,
        input  rd_value, rd_stall, stall_exec, pending_any, stall_cycles
    );

    // Forwarding unit side
    modport slave (
        input  rd_req, rd_orig, rd_en,
        input  src_wen, src_valid, src_reg, src_value,
        input  issue_valid, issue_reg,
        input  cmpl_valid, cmpl_reg, cmpl_value,
        input  flush,
        output rd_value, rd_stall, stall_exec, pending_any, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
//==============================================================================
// Module      : fwd_scoreboard
// Description : Operand forwarding unit with a long-latency writeback
//               scoreboard. Each read port takes its value from the youngest
//               matching bypass source, else the completion bus (if the
//               register is pending), else the register file. A stall is
//               raised when the newest producer has no value yet.
// Ports       : clk    - clock
//               resetn - synchronous active-low reset
//               bus    - fwd_scoreboard_if.slave (requests, bypass sources,
//                        issue/complete/flush, forwarded values and status)
// Parameters  : NUM_RD, NUM_SRC, DATA_W, REG_W as in the interface;
//               STALL_INIT - reset value of the stall-cycle counter
// Revision    : 1.0 - initial release
//==============================================================================
module fwd_scoreboard #(
    parameter int          NUM_RD     = 2,
    parameter int          NUM_SRC    = 3,
    parameter int          DATA_W     = 32,
    parameter int          REG_W      = 5,
    parameter logic [31:0] STALL_INIT = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            resetn,
    fwd_scoreboard_if.slave bus
);

    localparam int c_NUM_REGS = 1 << REG_W;

    logic [c_NUM_REGS-1:0]      r_pending;
    logic [c_NUM_REGS-1:0]      w_pending_nxt;
    logic                       r_pending_any;
    logic [31:0]                r_stall_cycles;

    logic [NUM_RD*DATA_W-1:0]   w_rd_value;
    logic [NUM_RD-1:0]          w_rd_stall;
    logic                       w_stall_exec;
    logic [REG_W-1:0]           w_req;
    logic [REG_W-1:0]           w_sreg;
    logic                       w_found;
    logic                       w_stall;

    //--------------------------------------------------------------------------
    // Per-port operand selection. w_found latches the first (youngest)
    // matching source so older sources can no longer override it, even when
    // the youngest match has no value yet and must stall.
    //--------------------------------------------------------------------------
    always_comb begin
        w_rd_value = '0;
        w_rd_stall = '0;
        w_req      = '0;
        w_sreg     = '0;
        w_found    = 1'b0;
        w_stall    = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_req   = bus.rd_req[p*REG_W +: REG_W];
            w_found = 1'b0;
            w_stall = 1'b0;
            w_rd_value[p*DATA_W +: DATA_W] = bus.rd_orig[p*DATA_W +: DATA_W];
            if (w_req == '0) begin
                w_rd_value[p*DATA_W +: DATA_W] = '0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    w_sreg = bus.src_reg[i*REG_W +: REG_W];
                    if (!w_found && bus.src_wen[i] && (w_sreg == w_req)) begin
                        w_found = 1'b1;
                        if (bus.src_valid[i]) begin
                            w_rd_value[p*DATA_W +: DATA_W] = bus.src_value[i*DATA_W +: DATA_W];
                        end else begin
                            w_stall = 1'b1;
                        end
                    end
                end
                if (!w_found) begin
                    // A completion only forwards when it matches an
                    // outstanding entry; stray completions are ignored.
                    if (bus.cmpl_valid && (bus.cmpl_reg == w_req) && r_pending[w_req]) begin
                        w_rd_value[p*DATA_W +: DATA_W] = bus.cmpl_value;
                    end else if (r_pending[w_req]) begin
                        w_stall = 1'b1;
                    end
                end
            end
            w_rd_stall[p] = w_stall & bus.rd_en[p];
        end
    end

    assign w_stall_exec = |w_rd_stall;

    //--------------------------------------------------------------------------
    // Pending bitmap next state. Issue is applied after complete so that a
    // same-register issue+complete leaves the bit set for the new producer.
    //--------------------------------------------------------------------------
    always_comb begin
        w_pending_nxt = r_pending;
        if (bus.flush) begin
            w_pending_nxt = '0;
        end else begin
            if (bus.cmpl_valid && r_pending[bus.cmpl_reg]) begin
                w_pending_nxt[bus.cmpl_reg] = 1'b0;
            end
            if (bus.issue_valid && (bus.issue_reg != '0)) begin
                w_pending_nxt[bus.issue_reg] = 1'b1;
            end
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pending      <= '0;
            r_pending_any  <= 1'b0;
            r_stall_cycles <= STALL_INIT;
        end else begin
            r_pending     <= w_pending_nxt;
            // Tracks the bitmap exactly: high whenever r_pending is nonzero.
            r_pending_any <= |w_pending_nxt;
            if (w_stall_exec && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign bus.rd_value     = w_rd_value;
    assign bus.rd_stall     = w_rd_stall;
    assign bus.stall_exec   = w_stall_exec;
    assign bus.pending_any  = r_pending_any;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding unit with a long-latency writeback scoreboard, sitting between decode/register-file read and the execute stage of the NaiveMIPS pipeline. For each of NUM_RD read ports it selects a register value from NUM_SRC prioritised pipeline bypass sources, a long-latency completion bus, or the register-file value. It raises a stall when the newest producer of a requested register has not yet produced its value. A pending-register bitmap tracks outstanding divider and load-miss writebacks, and a saturating counter records stall cycles for performance analysis.

## Interface
Parameters:
- NUM_RD, 2: number of operand read ports.
- NUM_SRC, 3: number of bypass sources; index 0 is youngest and highest priority.
- DATA_W, 32: data width.
- REG_W, 5: register index width; register 0 is hard-wired zero.

Ports (all vectors flattened, port/source i occupies slice [i*W +: W]):
- clk  in  1  clock; one clock domain.
- resetn  in  1  synchronous, active-low reset.
- rd_req  in  NUM_RD*REG_W  requested register per port.
- rd_orig  in  NUM_RD*DATA_W  register-file value per port.
- rd_en  in  NUM_RD  port is consumed by the instruction in decode; gates that port's stall.
- rd_value  out  NUM_RD*DATA_W  forwarded operand per port.
- rd_stall  out  NUM_RD  per-port stall, already gated by rd_en.
- stall_exec  out  1  OR of rd_stall.
- src_wen  in  NUM_SRC  source stage writes a register.
- src_valid  in  NUM_SRC  source value is available this cycle.
- src_reg  in  NUM_SRC*REG_W  destination of source.
- src_value  in  NUM_SRC*DATA_W  value of source.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_reg  in  REG_W  its destination.
- cmpl_valid  in  1  long-latency op completes this cycle.
- cmpl_reg  in  REG_W  completing destination.
- cmpl_value  in  DATA_W  completing value.
- flush  in  1  pipeline flush; kills all outstanding long-latency writebacks.
- pending_any  out  1  registered; some pending bit set.
- stall_cycles  out  32  registered, saturating stall-cycle counter.

## Operation
- Per-port priority, combinational, first rule that applies wins:
  1. req==0: value 0, no stall.
  2. Lowest i with src_wen[i] & src_reg[i]==req: if src_valid[i], value src_value[i], no stall; otherwise stall with value don't-care. Sources with src_wen=0 never match.
  3. cmpl_valid & cmpl_reg==req & pending[req]: value cmpl_value, no stall.
  4. pending[req]: stall.
  5. Otherwise: value rd_orig, no stall.
- rd_stall[p] = stall_p & rd_en[p]. rd_value is driven regardless of rd_en.
- Pending bitmap, 2^REG_W bits, updated on clk, evaluated in this order:
  - flush: all bits clear; same-cycle issue and complete are ignored.
  - Else complete: if cmpl_valid & pending[cmpl_reg], clear the bit. A complete for a non-pending register is ignored and is not forwarded.
  - Else issue: if issue_valid & issue_reg!=0, set the bit. When issue and complete hit the same register in the same cycle, issue wins and the bit stays 1. The old value is still forwarded that cycle by rule 3.
  - Bit 0 never sets.
- pending_any = |pending, taken from the registered bitmap.
- stall_cycles increments by 1 on each clk where stall_exec=1 and holds at 32'hFFFF_FFFF.

## Timing
- Reset (resetn=0 at the clk edge): pending all 0, pending_any 0, stall_cycles 0. This overrides flush, issue and stall counting in the same cycle. Forwarding outputs stay combinational during reset: with an empty bitmap they reflect only the src/orig rules.
- Forwarding and stall are zero-latency: the same cycle as their inputs.
- Issue in cycle t: bit visible to reads from t+1. Issue and read of the same register in cycle t does not stall via the scoreboard; the pipeline covers that case with src_wen.
- Completion in cycle t: forwarded in t, bit clear from t+1.
- Flush in cycle t: no scoreboard stalls from t+1. A completion arriving after the flush is dropped.
- stall_cycles and pending_any lag their cause by one cycle.

## Test plan
- Priority: src0 and src1 both target r5 with valid=1 and values 0x11 / 0x22, rd_req=5 → value 0x11, stall 0. Then drop src_valid[0] → stall_exec=1 even though src1 is valid. Then src_wen[0]=0 → 0x22.
- Zero register: rd_req=0 with a matching valid source of value 0xDEAD → value 0, no stall. issue_reg=0 → pending_any remains 0.
- Scoreboard: issue r8 at t. At t+1 reading r8 gives stall=1 on that port only, and rd_en=0 masks it. At t+3, cmpl r8 value 0xCAFE → value 0xCAFE, stall 0. At t+4, stall 0 with value = rd_orig. stall_cycles = 2.
- Same-cycle issue+complete on r9 (pending) → cmpl_value forwarded that cycle, pending[9] still 1 next cycle. Issue r3, flush next cycle, later cmpl r3 → r3 reads rd_orig and no stall after the flush.
- Reset mid-operation: pending r4, r7 and stall_cycles=10. Assert resetn=0 for one cycle → pending_any 0, stall_cycles 0, and a read of r4 does not stall.
- Counter saturation: force ~2^32 stall cycles, or preload via a bench parameter, then keep stalling → stall_cycles holds at 0xFFFFFFFF.
